// File: rtl/div_seq_ctrl.sv
// ============================================================================
// Module   : div_seq_ctrl
// Brief    : Sequential restoring divider for DIV/DIVU (one quotient bit per
//            clock) with sign fix-up, busy/ready handshake and flush-cancel.
//            Optional macro DIV_ZERO_FAST_EN: divide-by-zero skips iterations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_seq_ctrl #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              signed_i,
    input  logic [DATA_W-1:0] dividend_i,
    input  logic [DATA_W-1:0] divisor_i,
    input  logic              cancel_i,
    output logic              ready_o,
    output logic              busy_o,
    output logic              valid_o,
    output logic [DATA_W-1:0] quot_o,
    output logic [DATA_W-1:0] rem_o
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_rem;
    logic [DATA_W-1:0] r_quo;
    logic [DATA_W-1:0] r_div;
    logic              r_sign_q;
    logic              r_sign_r;
    logic [DATA_W-1:0] r_quot_out;
    logic [DATA_W-1:0] r_rem_out;

    logic              w_accept;
    logic              w_neg_a;
    logic              w_neg_b;
    logic [DATA_W-1:0] w_abs_a;
    logic [DATA_W-1:0] w_abs_b;
    logic [DATA_W:0]   w_rem_sh;
    logic [DATA_W:0]   w_diff;
    logic              w_ge;
    logic [DATA_W-1:0] w_rem_nx;
    logic [DATA_W-1:0] w_quo_nx;
    logic [DATA_W-1:0] w_fix_q;
    logic [DATA_W-1:0] w_fix_r;
    logic              w_last;

    assign w_accept = (r_state == c_IDLE) && start_i && !cancel_i;
    assign w_neg_a  = signed_i && dividend_i[DATA_W-1];
    assign w_neg_b  = signed_i && divisor_i[DATA_W-1];
    assign w_abs_a  = w_neg_a ? -dividend_i : dividend_i;
    assign w_abs_b  = w_neg_b ? -divisor_i  : divisor_i;

    // A borrow out of the widened subtraction means the partial remainder
    // is smaller than the divisor, so no separate comparator is needed.
    assign w_rem_sh = {r_rem, r_quo[DATA_W-1]};
    assign w_diff   = w_rem_sh - {1'b0, r_div};
    assign w_ge     = !w_diff[DATA_W];
    assign w_rem_nx = w_ge ? w_diff[DATA_W-1:0] : w_rem_sh[DATA_W-1:0];
    assign w_quo_nx = {r_quo[DATA_W-2:0], w_ge};
    assign w_fix_q  = r_sign_q ? -w_quo_nx : w_quo_nx;
    assign w_fix_r  = r_sign_r ? -w_rem_nx : w_rem_nx;
    assign w_last   = (r_cnt == c_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_cnt      <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_div      <= '0;
            r_sign_q   <= 1'b0;
            r_sign_r   <= 1'b0;
            r_quot_out <= '0;
            r_rem_out  <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_rem    <= '0;
                        r_quo    <= w_abs_a;
                        r_div    <= w_abs_b;
                        r_sign_q <= w_neg_a ^ w_neg_b;
                        r_sign_r <= w_neg_a;
                        r_cnt    <= '0;
`ifdef DIV_ZERO_FAST_EN
                        // Raw result is all-ones / |dividend|; after sign
                        // fix-up this is +/-1 and the original dividend.
                        if (divisor_i == '0) begin
                            r_state    <= c_DONE;
                            r_quot_out <= w_neg_a ? DATA_W'(1) : '1;
                            r_rem_out  <= dividend_i;
                        end else begin
                            r_state <= c_BUSY;
                        end
`else
                        r_state <= c_BUSY;
`endif
                    end
                end
                c_BUSY: begin
                    if (cancel_i) begin
                        r_state <= c_IDLE;
                    end else begin
                        r_rem <= w_rem_nx;
                        r_quo <= w_quo_nx;
                        r_cnt <= r_cnt + c_ONE;
                        if (w_last) begin
                            r_state    <= c_DONE;
                            r_quot_out <= w_fix_q;
                            r_rem_out  <= w_fix_r;
                        end
                    end
                end
                c_DONE:  r_state <= c_IDLE;
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign ready_o = (r_state == c_IDLE);
    assign busy_o  = (r_state == c_BUSY);
    assign valid_o = (r_state == c_DONE);
    assign quot_o  = r_quot_out;
    assign rem_o   = r_rem_out;

endmodule

`default_nettype wire

// File: tb/tb_div_seq_ctrl.sv
// ============================================================================
// Module   : tb_div_seq_ctrl
// Brief    : Directed self-checking bench for div_seq_ctrl with a result
//            scoreboard compared on every valid_o pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        signed_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic        cancel_i;
    logic        ready_o;
    logic        busy_o;
    logic        valid_o;
    logic [31:0] quot_o;
    logic [31:0] rem_o;

    int          n_chk   = 0;
    int          n_pass  = 0;
    int          n_valid = 0;
    logic [63:0] sb[$];

    div_seq_ctrl #(.DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .signed_i   (signed_i),
        .dividend_i (dividend_i),
        .divisor_i  (divisor_i),
        .cancel_i   (cancel_i),
        .ready_o    (ready_o),
        .busy_o     (busy_o),
        .valid_o    (valid_o),
        .quot_o     (quot_o),
        .rem_o      (rem_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Scoreboard: every valid pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        logic [63:0] e;
        if (!rst && valid_o) begin
            n_valid++;
            if (sb.size() == 0) begin
                chk("unexpected_valid", 64'(valid_o), 64'd0);
            end else begin
                e = sb.pop_front();
                chk("quot", 64'(quot_o), 64'(e[63:32]));
                chk("rem",  64'(rem_o),  64'(e[31:0]));
            end
        end
    end

    task automatic run_op(input logic sg, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] q, input logic [31:0] r);
        int lat;
        int exp_lat;
        bit busy_ok;
        for (int i = 0; i < 40 && !ready_o; i++) tick();
        chk("ready_before_accept", 64'(ready_o), 64'd1);
`ifdef DIV_ZERO_FAST_EN
        exp_lat = (b == 32'd0) ? 1 : 33;
`else
        exp_lat = 33;
`endif
        start_i    = 1'b1;
        signed_i   = sg;
        dividend_i = a;
        divisor_i  = b;
        sb.push_back({q, r});
        tick();
        start_i    = 1'b0;
        dividend_i = $urandom;
        divisor_i  = $urandom;
        lat        = 1;
        busy_ok    = 1'b1;
        while (!valid_o && lat < 40) begin
            if (busy_o !== 1'b1) busy_ok = 1'b0;
            tick();
            lat++;
        end
        chk("latency", 64'(lat), 64'(exp_lat));
        chk("busy_while_running", 64'(busy_ok), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a, b, q, r;
        logic        sg;
        int          lat;
        int          v0;

        rst = 1'b1; start_i = 1'b0; signed_i = 1'b0; cancel_i = 1'b0;
        dividend_i = '0; divisor_i = '0;
        repeat (3) tick();
        chk("rst_ready", 64'(ready_o), 64'd1);
        chk("rst_busy",  64'(busy_o),  64'd0);
        chk("rst_valid", 64'(valid_o), 64'd0);
        chk("rst_quot",  64'(quot_o),  64'd0);
        chk("rst_rem",   64'(rem_o),   64'd0);
        rst = 1'b0;
        tick();

        run_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
        tick();
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        tick();
        run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
        tick();
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
        tick();
        run_op(1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5);
        tick();
        run_op(1'b1, 32'hFFFF_FFFB, 32'd0, 32'd1, 32'hFFFF_FFFB);
        tick();

        // Request together with cancel in IDLE is dropped.
        start_i = 1'b1; cancel_i = 1'b1; signed_i = 1'b0;
        dividend_i = 32'd1; divisor_i = 32'd1;
        tick();
        start_i = 1'b0; cancel_i = 1'b0;
        chk("cancel_idle_ready", 64'(ready_o), 64'd1);
        chk("cancel_idle_busy",  64'(busy_o),  64'd0);

        // Cancel mid-operation: previous result must survive.
        start_i = 1'b1; dividend_i = 32'd100; divisor_i = 32'd7;
        tick();
        start_i = 1'b0;
        repeat (9) tick();
        chk("busy_before_cancel", 64'(busy_o), 64'd1);
        cancel_i = 1'b1;
        tick();
        cancel_i = 1'b0;
        chk("cancel_ready", 64'(ready_o), 64'd1);
        chk("cancel_busy",  64'(busy_o),  64'd0);
        chk("cancel_valid", 64'(valid_o), 64'd0);
        chk("cancel_quot_kept", 64'(quot_o), 64'd1);
        chk("cancel_rem_kept",  64'(rem_o),  64'h0000_0000_FFFF_FFFB);
        run_op(1'b0, 32'd9, 32'd3, 32'd3, 32'd0);
        tick();

        // start_i held through BUSY and DONE with changing operands.
        start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd1000; divisor_i = 32'd7;
        sb.push_back({32'd142, 32'd6});
        tick();
        lat = 1;
        while (!valid_o && lat < 40) begin
            dividend_i = $urandom;
            divisor_i  = $urandom_range(1, 50);
            signed_i   = 1'($urandom_range(0, 1));
            tick();
            lat++;
        end
        chk("hold_latency", 64'(lat), 64'd33);
        tick();
        start_i = 1'b0;
        chk("no_accept_in_done_ready", 64'(ready_o), 64'd1);
        chk("no_accept_in_done_busy",  64'(busy_o),  64'd0);

        // Reset in the middle of an operation.
        signed_i = 1'b0; start_i = 1'b1; dividend_i = 32'd50; divisor_i = 32'd5;
        tick();
        start_i = 1'b0;
        repeat (14) tick();
        rst = 1'b1;
        tick();
        chk("midrst_ready", 64'(ready_o), 64'd1);
        chk("midrst_busy",  64'(busy_o),  64'd0);
        chk("midrst_valid", 64'(valid_o), 64'd0);
        chk("midrst_quot",  64'(quot_o),  64'd0);
        chk("midrst_rem",   64'(rem_o),   64'd0);
        rst = 1'b0;
        tick();

        // Back-to-back: continuous start accepted once every 34 cycles.
        v0 = n_valid;
        start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd1000; divisor_i = 32'd33;
        for (int cyc = 0; cyc < 102; cyc++) begin
            chk("b2b_ready", 64'(ready_o), 64'((cyc % 34) == 0));
            if (ready_o) sb.push_back({32'd30, 32'd10});
            tick();
        end
        start_i = 1'b0;
        chk("b2b_valid_count", 64'(n_valid - v0), 64'd3);
        tick();

        for (int k = 0; k < 4; k++) begin
            sg = 1'(k & 1);
            a  = $urandom;
            b  = (k < 2) ? 32'($urandom_range(1, 1000)) : $urandom;
            if (b == 32'd0) b = 32'd1;
            if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
            if (sg) begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end else begin
                q = a / b;
                r = a % b;
            end
            run_op(sg, a, b, q, r);
            tick();
        end

        repeat (3) tick();
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
